// File: rtl/md_sequencer.sv
// md_sequencer: fixed-latency multiply/divide sequencer owning the HI/LO pair
module md_sequencer #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        d_uses_md,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        stall_md
);
   localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAXC + 1);
   localparam logic [CW-1:0] MC = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DC = CW'(DIV_CYCLES);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;
   logic [0:0] state;
   logic [CW-1:0] count;
   logic [31:0] p_hi, p_lo;
   logic p_we;
   logic is_md, is_div, ovf;
   logic [31:0] bs, bu, uq, ur;
   logic signed [31:0] sq, sr;
   logic signed [63:0] sp;
   logic [63:0] up, res;
   assign is_md    = md_op >= 3'd1 && md_op <= 3'd4;
   assign is_div   = md_op == 3'd3 || md_op == 3'd4;
   assign ovf      = a == 32'h8000_0000 && b == 32'hffff_ffff;
   assign bs       = (b == 32'd0 || ovf) ? 32'd1 : b;
   assign bu       = b == 32'd0 ? 32'd1 : b;
   assign sp       = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign up       = {32'd0, a} * {32'd0, b};
   assign sq       = $signed(a) / $signed(bs);
   assign sr       = $signed(a) % $signed(bs);
   assign uq       = a / bu;
   assign ur       = a % bu;
   assign busy     = state == RUN;
   assign stall_md = d_uses_md & (busy | (start & is_md));
   // full 64-bit result of the command presented this cycle
   always_comb begin
      res = md_op == 3'd1 ? sp :
            md_op == 3'd2 ? up :
            md_op == 3'd3 ? {ovf ? 32'd0 : sr, ovf ? 32'h8000_0000 : sq} :
                            {ur, uq};
   end
   // issue, countdown and HI/LO commit; commands arriving while busy are dropped
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         hi    <= '0;
         lo    <= '0;
         p_hi  <= '0;
         p_lo  <= '0;
         p_we  <= 1'b0;
      end else if (state == RUN) begin
         count <= count - 1'b1;
         if (count == CW'(1)) begin
            state <= IDLE;
            if (p_we) begin
               hi <= p_hi;
               lo <= p_lo;
            end
         end
      end else if (start) begin
         if (is_md) begin
            state <= RUN;
            count <= is_div ? DC : MC;
            p_hi  <= res[63:32];
            p_lo  <= res[31:0];
            p_we  <= !(is_div && b == 32'd0);
         end else if (md_op == 3'd5) begin
            hi <= a;
         end else if (md_op == 3'd6) begin
            lo <= a;
         end
      end
   end
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: scoreboard bench for md_sequencer against a longint reference model
module tb_md_sequencer;
   localparam int M = 5;
   localparam int D = 10;
   logic clk = 1'b0;
   logic reset, start, d_uses_md;
   logic [2:0] md_op;
   logic [31:0] a, b, hi, lo;
   logic busy, stall_md;
   typedef struct {
      logic [31:0] h;
      logic [31:0] l;
      int n;
   } exp_t;
   exp_t q[$];
   exp_t me;
   int checks = 0;
   int errors = 0;
   int run = 0;
   logic [31:0] m_hi = 0, m_lo = 0;
   md_sequencer #(.MULT_CYCLES(M), .DIV_CYCLES(D)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
      .d_uses_md(d_uses_md), .busy(busy), .hi(hi), .lo(lo), .stall_md(stall_md)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   // architectural result of one command given the prior HI/LO
   function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] x, y, oh, ol);
      longint sx, sy, qq, rm;
      logic [63:0] r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      r = {oh, ol};
      if (op == 1) r = sx * sy;
      else if (op == 2) r = {32'd0, x} * {32'd0, y};
      else if (op == 3 && y != 0) begin
         qq = sx / sy;
         rm = sx % sy;
         r = {rm[31:0], qq[31:0]};
      end else if (op == 4 && y != 0) r = {x % y, x / y};
      return r;
   endfunction
   // completion monitor: each busy window must match the next expected entry
   always @(negedge clk) begin
      if (reset) run = 0;
      else if (busy) run++;
      else if (run > 0) begin
         if (q.size() == 0) chk("unexpected_completion", 32'd1, 32'd0);
         else begin
            me = q.pop_front();
            chk("sb_hi", hi, me.h);
            chk("sb_lo", lo, me.l);
            chk("sb_busy_len", run, me.n);
         end
         run = 0;
      end
   end
   task automatic issue(input logic [2:0] op, input logic [31:0] x, y, input logic du);
      logic [63:0] r;
      exp_t e;
      @(posedge clk); #1;
      start = 1; md_op = op; a = x; b = y; d_uses_md = du;
      #1 chk("stall_issue", stall_md, du & (op >= 1 && op <= 4));
      if (op >= 1 && op <= 4) begin
         r = ref_md(op, x, y, m_hi, m_lo);
         e.h = r[63:32]; e.l = r[31:0]; e.n = (op >= 3) ? D : M;
         q.push_back(e);
         m_hi = e.h; m_lo = e.l;
      end else if (op == 5) m_hi = x;
      else if (op == 6) m_lo = x;
      @(posedge clk); #1;
      start = 0; d_uses_md = 0;
      if (op >= 5) begin
         chk("mt_hi", hi, m_hi);
         chk("mt_lo", lo, m_lo);
         chk("mt_busy", busy, 0);
      end
   endtask
   task automatic wait_idle();
      for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
      chk("timeout", q.size(), 0);
      @(posedge clk); #1;
   endtask
   initial begin
      logic [31:0] old_hi, old_lo, x, y;
      logic [2:0] op;
      reset = 1; start = 0; md_op = 0; a = 0; b = 0; d_uses_md = 1;
      repeat (3) @(posedge clk);
      #1 reset = 0;
      chk("rst_busy", busy, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_stall", stall_md, 0);
      d_uses_md = 0;
      // mult with D-stage md user held; ignored mthi mid-flight
      old_hi = hi; old_lo = lo;
      issue(3'd1, 32'hffff_fffd, 32'd5, 1'b1);
      d_uses_md = 1;
      for (int i = 0; i < M; i++) begin
         chk("run_stall", stall_md, 1);
         chk("run_busy", busy, 1);
         chk("run_hi_held", hi, old_hi);
         chk("run_lo_held", lo, old_lo);
         if (i == 2) begin
            start = 1; md_op = 3'd5; a = 32'hdead;
         end
         @(posedge clk); #1;
         start = 0;
      end
      chk("post_stall", stall_md, 0);
      chk("post_busy", busy, 0);
      chk("mult_hi", hi, 32'hffff_ffff);
      chk("mult_lo", lo, 32'hffff_fff1);
      d_uses_md = 0;
      wait_idle();
      issue(3'd2, 32'hffff_ffff, 32'd2, 1'b0);
      wait_idle();
      chk("multu_hi", hi, 32'h1);
      chk("multu_lo", lo, 32'hffff_fffe);
      issue(3'd3, 32'hffff_fff9, 32'd2, 1'b1);
      wait_idle();
      chk("div_hi", hi, 32'hffff_ffff);
      chk("div_lo", lo, 32'hffff_fffd);
      issue(3'd5, 32'h1234, 32'd0, 1'b1);
      issue(3'd6, 32'h5678, 32'd0, 1'b0);
      issue(3'd4, 32'd100, 32'd0, 1'b0);
      wait_idle();
      chk("divz_hi", hi, 32'h1234);
      chk("divz_lo", lo, 32'h5678);
      issue(3'd3, 32'h8000_0000, 32'hffff_ffff, 1'b0);
      wait_idle();
      chk("ovf_hi", hi, 32'h0);
      chk("ovf_lo", lo, 32'h8000_0000);
      issue(3'd0, 32'hffff, 32'd1, 1'b1);
      issue(3'd7, 32'hffff, 32'd1, 1'b1);
      chk("nop_busy", busy, 0);
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(1, 6));
         x = $urandom;
         y = $urandom_range(0, 4) == 0 ? 32'd0 : $urandom;
         if ($urandom_range(0, 7) == 0) begin x = 32'h8000_0000; y = 32'hffff_ffff; end
         if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(1, 9));
         issue(op, x, y, 1'($urandom_range(0, 1)));
         wait_idle();
      end
      // reset during the third busy cycle of a divide discards it
      issue(3'd5, 32'h0bad_cafe, 32'd0, 1'b0);
      issue(3'd3, 32'hffff_fff9, 32'd2, 1'b0);
      repeat (2) @(posedge clk);
      #1 reset = 1;
      @(posedge clk); #1;
      reset = 0;
      q.delete();
      chk("abort_busy", busy, 0);
      chk("abort_hi", hi, 0);
      chk("abort_lo", lo, 0);
      repeat (12) @(posedge clk);
      #1;
      chk("late_busy", busy, 0);
      chk("late_hi", hi, 0);
      chk("late_lo", lo, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
